mux_82_rr_arb: RTL and testbench
================================

MUX_82_RR_ARB -- requirements
Module: mux_82_rr_arb

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every input word and of out.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request vector; bit0 = d1, bit1 = d2, bit2 = d3, bit3 = d4.
REQ-005 d1, d2, d3, d4  input  WIDTH each  requester data words.
REQ-006 out_ready  input  1  downstream accepts out this cycle.
REQ-007 out  output  WIDTH  registered copy of the granted requester's data.
REQ-008 sel  output  2  index of the requester whose word is in out (00 = d1 … 11 = d4).
REQ-009 out_valid  output  1  out holds an untransferred word.
REQ-010 gnt  output  4  one-hot, one-cycle grant acknowledge; all zero otherwise.

Function
REQ-011 The block SHALL use two states: IDLE (out_valid = 0) and HOLD (out_valid = 1).
REQ-012 The block SHALL be "free" in a cycle when state = IDLE, or when state = HOLD and out_ready = 1.
REQ-013 The eligible set SHALL be req with bit i masked in any cycle where gnt[i] = 1.
- Purpose: the just-granted requester is not re-granted on its stale req.
REQ-014 When free and the eligible set is non-zero, the winner SHALL be the first eligible bit scanning ptr, ptr+1, … modulo 4.
REQ-015 On a win at edge E, the block SHALL:
- load out <= d[winner] and sel <= winner;
- set state = HOLD;
- set ptr <= (winner + 1) mod 4;
- assert gnt[winner] for exactly the one cycle following E.
REQ-016 When free and the eligible set is zero, the block SHALL go to IDLE and deassert out_valid.
- out, sel and ptr SHALL retain their values.
REQ-017 In HOLD with out_ready = 0, the block SHALL hold out, sel, out_valid and ptr stable and keep gnt = 0.
- Changes on req or d1..d4 SHALL have no effect.
REQ-018 In HOLD with out_ready = 1 and an eligible request, the block SHALL complete the transfer and capture the new winner in the same edge.
- Result: back-to-back throughput of one word per cycle.
REQ-019 Latency SHALL be one cycle: req sampled at edge E gives out_valid, out, sel and gnt visible after E.
REQ-020 Each requester SHALL hold req and data stable until it sees gnt; unselected data words are don't-care.
REQ-021 Any continuously asserted eligible request SHALL be granted within 4 grants (round-robin fairness).
REQ-022 A single requester holding req continuously SHALL be granted at most every second cycle (REQ-013 mask).

Reset
REQ-023 While rst_n = 0, the block SHALL immediately force, independent of clk:
- out = 0, sel = 00, out_valid = 0, gnt = 0000;
- ptr = 0, state = IDLE.
REQ-024 Reset asserted mid-HOLD SHALL discard the held word; no gnt is issued for it afterwards.
REQ-025 Arbitration SHALL resume on the first rising edge after rst_n returns to 1.

Verification
REQ-026 Single request: after reset, req = 0001, d1 = 8'h01, out_ready = 1
- next edge: out = 8'h01, sel = 00, out_valid = 1, gnt = 0001 for one cycle;
- req = 0000 at the following edge: out_valid = 0, out stays 8'h01.
REQ-027 Round-robin: d1..d4 = 01, 02, 03, 04, req = 1111 held, out_ready = 1
- sel sequence SHALL be 00, 01, 10, 11, 00, …;
- out sequence SHALL be 01, 02, 03, 04, … at one word per cycle;
- gnt SHALL follow one-hot in the same order.
REQ-028 Backpressure: req = 0100, d3 = 8'h33, out_ready = 0
- out = 8'h33 and out_valid = 1 held for 5 cycles;
- changing d3 to 8'h55 leaves out = 8'h33;
- exactly one gnt = 0100 pulse.
REQ-029 Wrap-around:
- after a grant to d4 (sel = 11), req = 1001 SHALL grant d1 (sel = 00);
- after a grant to d1, req = 1001 SHALL grant d4.
REQ-030 Reset mid-HOLD: assert rst_n = 0 with out_valid = 1, out_ready = 0
- outputs SHALL zero without a clock edge;
- after release, req = 1000 SHALL grant d4 with sel = 11.
REQ-031 Mask: req = 0010 held, out_ready = 1
- out_valid pattern SHALL be 1, 0, 1, 0, …;
- gnt = 0010 SHALL pulse every second cycle.

Source files
------------

// File: rtl/mux_82_rr_arb_if.sv
// Bus bundle for the 4:1 round-robin arbitrating mux: requester side in, registered word out.
interface mux_82_rr_arb_if #(parameter int WIDTH = 8);
  logic [3:0]       req;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [WIDTH-1:0] d4;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [1:0]       sel;
  logic             out_valid;
  logic [3:0]       gnt;

  modport master (
    output req, d1, d2, d3, d4, out_ready,
    input  out, sel, out_valid, gnt
  );

  modport slave (
    input  req, d1, d2, d3, d4, out_ready,
    output out, sel, out_valid, gnt
  );
endinterface

// File: rtl/mux_82_rr_arb.sv
// Four-requester round-robin arbiter with a one-word registered output stage.
// The requester granted last cycle is masked so its stale req is not re-granted.
module mux_82_rr_arb #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  mux_82_rr_arb_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       ptr;
  logic [1:0]       winner;
  logic [1:0]       idx;
  logic [3:0]       elig;
  logic             found;
  logic             free;
  logic             win;
  logic [WIDTH-1:0] win_data;

  // Arbitration: scan eligible requests starting at ptr, wrapping modulo 4.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    free   = (state == IDLE) || bus.out_ready;
    elig   = bus.req & ~bus.gnt;
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    win = free && found;
  end

  always_comb begin
    win_data = bus.d1;
    case (winner)
      2'd0: win_data = bus.d1;
      2'd1: win_data = bus.d2;
      2'd2: win_data = bus.d3;
      2'd3: win_data = bus.d4;
      default: win_data = bus.d1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (free) state_nxt = win ? HOLD : IDLE;
  end

  always_comb begin
    bus.out_valid = (state == HOLD);
  end

  // Data, index and pointer only move on a win; going idle keeps them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out <= '0;
      bus.sel <= 2'd0;
      bus.gnt <= 4'b0000;
      ptr     <= 2'd0;
    end else begin
      bus.gnt <= win ? (4'b0001 << winner) : 4'b0000;
      if (win) begin
        bus.out <= win_data;
        bus.sel <= winner;
        ptr     <= winner + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mux_82_rr_arb.sv
// Bench for mux_82_rr_arb: directed scenarios plus random traffic, scored against
// a cycle-level behavioural model through an expected-response queue.
module tb_mux_82_rr_arb;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] out;
    logic [1:0]       sel;
    logic [3:0]       gnt;
  } exp_t;

  logic clk;
  logic rst_n;

  mux_82_rr_arb_if #(.WIDTH(WIDTH)) bus ();

  mux_82_rr_arb #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_push = 0;
  int   n_pop  = 0;
  exp_t sb[$];

  // Reference model state, expressed in terms of the arbitration rules.
  int               m_ptr  = 0;
  int               m_last = -1;
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_out  = '0;
  int               m_sel  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    n_chk++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req_v, $time);
  endtask

  // Predict the bus state after the coming rising edge, given this cycle's inputs.
  function automatic exp_t model_edge(input logic r, input logic [3:0] rq,
                                      input logic [WIDTH-1:0] w1, input logic [WIDTH-1:0] w2,
                                      input logic [WIDTH-1:0] w3, input logic [WIDTH-1:0] w4,
                                      input logic rdy);
    exp_t             e;
    logic [WIDTH-1:0] words [4];
    int               w;
    words[0] = w1; words[1] = w2; words[2] = w3; words[3] = w4;
    w = -1;
    if (!r) begin
      m_ptr = 0; m_last = -1; m_valid = 1'b0; m_out = '0; m_sel = 0;
    end else if (!m_valid || rdy) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (w < 0 && rq[i] && i != m_last) w = i;
      end
      if (w >= 0) begin
        m_out = words[w]; m_sel = w; m_valid = 1'b1; m_ptr = (w + 1) % 4;
      end else begin
        m_valid = 1'b0;
      end
      m_last = w;
    end else begin
      m_last = -1;
    end
    e.valid = m_valid;
    e.out   = m_out;
    e.sel   = 2'(m_sel);
    e.gnt   = (w >= 0) ? 4'(1 << w) : 4'b0000;
    return e;
  endfunction

  task automatic step(input logic r, input logic [3:0] rq,
                      input logic [WIDTH-1:0] w1, input logic [WIDTH-1:0] w2,
                      input logic [WIDTH-1:0] w3, input logic [WIDTH-1:0] w4,
                      input logic rdy);
    @(negedge clk);
    rst_n         = r;
    bus.req       = rq;
    bus.d1        = w1;
    bus.d2        = w2;
    bus.d3        = w3;
    bus.d4        = w4;
    bus.out_ready = rdy;
    if (!r) begin
      #1;
      check("async_reset_outputs", {bus.out_valid, bus.out, bus.sel, bus.gnt}, '0);
    end
    sb.push_back(model_edge(r, rq, w1, w2, w3, w4, rdy));
    n_push++;
  endtask

  // Monitor: after each rising edge compare the bus with the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_pop++;
        check("bus_after_edge", {bus.out_valid, bus.out, bus.sel, bus.gnt}, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.req = 4'b0000;
    bus.d1 = '0; bus.d2 = '0; bus.d3 = '0; bus.d4 = '0;
    bus.out_ready = 1'b0;

    // Reset state and single request.
    step(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    step(1, 4'b0001, 8'h01, 8'h00, 8'h00, 8'h00, 1);
    step(1, 4'b0000, 8'h01, 8'h00, 8'h00, 8'h00, 1);
    step(1, 4'b0000, 8'h01, 8'h00, 8'h00, 8'h00, 1);

    // Round-robin over all four at one word per cycle.
    step(0, 4'b0000, 8'h01, 8'h02, 8'h03, 8'h04, 1);
    for (int i = 0; i < 9; i++) step(1, 4'b1111, 8'h01, 8'h02, 8'h03, 8'h04, 1);

    // Backpressure: one grant, word held while d3 changes.
    step(0, 4'b0000, 8'h00, 8'h00, 8'h33, 8'h00, 0);
    step(1, 4'b0100, 8'h00, 8'h00, 8'h33, 8'h00, 0);
    for (int i = 0; i < 2; i++) step(1, 4'b0100, 8'h00, 8'h00, 8'h33, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(1, 4'b0100, 8'h00, 8'h00, 8'h55, 8'h00, 0);
    step(1, 4'b0000, 8'h00, 8'h00, 8'h55, 8'h00, 1);

    // Wrap-around between d4 and d1.
    step(0, 4'b0000, 8'hA1, 8'h00, 8'h00, 8'hA4, 1);
    step(1, 4'b1000, 8'hA1, 8'h00, 8'h00, 8'hA4, 1);
    step(1, 4'b1001, 8'hA1, 8'h00, 8'h00, 8'hA4, 1);
    step(1, 4'b1001, 8'hA1, 8'h00, 8'h00, 8'hA4, 1);
    step(1, 4'b0000, 8'hA1, 8'h00, 8'h00, 8'hA4, 1);

    // Reset while holding a word, then grant d4 after release.
    step(1, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h44, 0);
    step(1, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h44, 0);
    step(0, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h44, 0);
    step(1, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h48, 0);
    step(1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h48, 1);

    // Mask: lone requester granted every second cycle.
    step(0, 4'b0000, 8'h00, 8'h22, 8'h00, 8'h00, 1);
    for (int i = 0; i < 6; i++) step(1, 4'b0010, 8'h00, 8'h22, 8'h00, 8'h00, 1);

    // Random traffic with occasional backpressure and resets.
    for (int i = 0; i < 400; i++) begin
      logic r;
      r = ($urandom_range(0, 63) != 0);
      step(r, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 9) < 7));
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("pop_count", 64'(n_pop), 64'(n_push));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
